// File: rtl/doom_keys_pkg.sv
// doom_keys_pkg
// Shared definitions for the PS/2 key decoder:
//   - byte-parse FSM state encoding
//   - PS/2 scan-code constants (prefixes, arrow keys, WASD letters)
//   - one-hot direction encodings (RIGHT=1000, LEFT=0100, UP=0010, DOWN=0001)
//   - helper functions mapping scan codes to directions and picking the
//     fixed-priority held direction
// No ports (package).

package doom_keys_pkg;

  // Byte-parse FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,  // waiting for a new code
    ST_EXT     = 2'b01,  // E0 seen
    ST_BRK     = 2'b10,  // F0 seen
    ST_EXT_BRK = 2'b11   // E0 then F0 seen
  } kd_state_e;

  // Width of the prefix timeout counter
  localparam int TIMEOUT_W = 20;

  // Prefix bytes
  localparam logic [7:0] SC_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] SC_PREFIX_BRK = 8'hF0;

  // Extended (E0-prefixed) arrow-key codes
  localparam logic [7:0] SC_ARROW_RIGHT = 8'h74;
  localparam logic [7:0] SC_ARROW_LEFT  = 8'h6B;
  localparam logic [7:0] SC_ARROW_UP    = 8'h75;
  localparam logic [7:0] SC_ARROW_DOWN  = 8'h72;

  // Non-extended letter codes used as optional aliases
  localparam logic [7:0] SC_KEY_W = 8'h1D;
  localparam logic [7:0] SC_KEY_A = 8'h1C;
  localparam logic [7:0] SC_KEY_S = 8'h1B;
  localparam logic [7:0] SC_KEY_D = 8'h23;

  // One-hot direction encodings; bit order matches priority (MSB highest)
  localparam logic [3:0] DIR_RIGHT = 4'b1000;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_UP    = 4'b0010;
  localparam logic [3:0] DIR_DOWN  = 4'b0001;
  localparam logic [3:0] DIR_NONE  = 4'b0000;

  // Map an extended code to its direction; untracked codes give DIR_NONE.
  function automatic logic [3:0] arrow_code_dir(input logic [7:0] code);
    logic [3:0] dir;
    case (code)
      SC_ARROW_RIGHT: dir = DIR_RIGHT;
      SC_ARROW_LEFT:  dir = DIR_LEFT;
      SC_ARROW_UP:    dir = DIR_UP;
      SC_ARROW_DOWN:  dir = DIR_DOWN;
      default:        dir = DIR_NONE;
    endcase
    return dir;
  endfunction

  // Map a non-extended letter code to its aliased direction.
  function automatic logic [3:0] wasd_code_dir(input logic [7:0] code);
    logic [3:0] dir;
    case (code)
      SC_KEY_D: dir = DIR_RIGHT;
      SC_KEY_A: dir = DIR_LEFT;
      SC_KEY_W: dir = DIR_UP;
      SC_KEY_S: dir = DIR_DOWN;
      default:  dir = DIR_NONE;
    endcase
    return dir;
  endfunction

  // Highest-priority held direction: right > left > up > down.
  function automatic logic [3:0] priority_pick(input logic [3:0] held);
    logic [3:0] dir;
    if (held[3]) begin
      dir = DIR_RIGHT;
    end else if (held[2]) begin
      dir = DIR_LEFT;
    end else if (held[1]) begin
      dir = DIR_UP;
    end else if (held[0]) begin
      dir = DIR_DOWN;
    end else begin
      dir = DIR_NONE;
    end
    return dir;
  endfunction

endpackage

// File: rtl/key_priority_resolve.sv
// key_priority_resolve
// Purely combinational choice of the single active direction.
// The most recently pressed key wins while it is still held; otherwise the
// fixed priority right > left > up > down applies; nothing held -> zero.
// Ports:
//   held_i [3:0]  held directions (arrow and alias keys already merged)
//   last_i [3:0]  one-hot most recently made direction (or zero)
//   dir_o  [3:0]  one-hot or all-zero resolved direction

module key_priority_resolve
  import doom_keys_pkg::*;
(
  input  logic [3:0] held_i,
  input  logic [3:0] last_i,
  output logic [3:0] dir_o
);

  logic last_held_s;

  // last_i is one-hot, so any overlap means the latest key is still down
  assign last_held_s = |(held_i & last_i);

  // Resolve most-recent versus fixed priority
  always_comb begin
    dir_o = DIR_NONE;
    if (last_held_s) begin
      dir_o = last_i;
    end else begin
      dir_o = priority_pick(held_i);
    end
  end

endmodule

// File: rtl/key_decoder.sv
// key_decoder
// Decodes PS/2 scan-code bytes into the four movement controls of the player
// updater. A four-state FSM tracks E0/F0 prefixes; make/break codes of the
// arrow keys set/clear held bits; a combinational resolver picks one
// direction which is registered onto the outputs one cycle after the byte
// that completes a code. A prefix not followed by a byte within
// PREFIX_TIMEOUT cycles is abandoned (held keys are kept).
// Optional feature macro: KEY_WASD_EN -- when defined, the non-extended codes
// W/A/S/D alias up/left/down/right with their own held bits; when undefined
// those codes are ignored like any other untracked code.
// Ports:
//   clock          system clock
//   reset          asynchronous, active-high reset
//   byte_valid     one-cycle strobe qualifying byte_data
//   byte_data[7:0] scan-code byte from the serial receiver
//   turn_right     registered direction output
//   turn_left      registered direction output
//   move_forward   registered direction output
//   move_backward  registered direction output
//   any_key        registered, high while any tracked key is held

module key_decoder
  import doom_keys_pkg::*;
#(
  parameter int PREFIX_TIMEOUT = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       turn_right,
  output logic       turn_left,
  output logic       move_forward,
  output logic       move_backward,
  output logic       any_key
);

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(PREFIX_TIMEOUT - 1);

  kd_state_e              state_q, state_d;
  logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]             held_arrow_q, held_arrow_d;
  logic [3:0]             held_wasd_q, held_wasd_d;
  logic [3:0]             last_q, last_d;
  logic [3:0]             dir_q;
  logic                   any_key_q;

  logic [3:0]             arrow_dir_s;
  logic [3:0]             wasd_dir_s;
  logic [3:0]             held_all_s;
  logic [3:0]             dir_s;
  logic                   is_ext_s;
  logic                   is_brk_s;

  assign arrow_dir_s = arrow_code_dir(byte_data);

`ifdef KEY_WASD_EN
  assign wasd_dir_s = wasd_code_dir(byte_data);
`else
  // Letter codes are not tracked in this build
  assign wasd_dir_s = DIR_NONE;
`endif

  assign is_ext_s = (byte_data == SC_PREFIX_EXT);
  assign is_brk_s = (byte_data == SC_PREFIX_BRK);

  // Next-state logic: prefix parsing, held/last bookkeeping and timeout
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    held_arrow_d = held_arrow_q;
    held_wasd_d  = held_wasd_q;
    last_d       = last_q;
    if (byte_valid) begin
      // A byte always wins over a coincident timeout
      cnt_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (is_ext_s) begin
            state_d = ST_EXT;
          end else if (is_brk_s) begin
            state_d = ST_BRK;
          end else begin
            // Non-extended make; only a fresh press moves last (typematic
            // repeats of a held key change nothing)
            if ((wasd_dir_s & ~held_wasd_q) != DIR_NONE) begin
              held_wasd_d = held_wasd_q | wasd_dir_s;
              last_d      = wasd_dir_s;
            end else begin
              held_wasd_d = held_wasd_q;
            end
            state_d = ST_IDLE;
          end
        end
        ST_EXT: begin
          if (is_brk_s) begin
            state_d = ST_EXT_BRK;
          end else begin
            if ((arrow_dir_s & ~held_arrow_q) != DIR_NONE) begin
              held_arrow_d = held_arrow_q | arrow_dir_s;
              last_d       = arrow_dir_s;
            end else begin
              held_arrow_d = held_arrow_q;
            end
            state_d = ST_IDLE;
          end
        end
        ST_BRK: begin
          // Clearing a bit that is already clear is harmless
          held_wasd_d = held_wasd_q & ~wasd_dir_s;
          state_d     = ST_IDLE;
        end
        ST_EXT_BRK: begin
          held_arrow_d = held_arrow_q & ~arrow_dir_s;
          state_d      = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else if (state_q != ST_IDLE) begin
      if (cnt_q == TIMEOUT_LAST) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_d = '0;
    end
  end

  assign held_all_s = held_arrow_d | held_wasd_d;

  key_priority_resolve u_resolve (
    .held_i (held_all_s),
    .last_i (last_d),
    .dir_o  (dir_s)
  );

  // State, bookkeeping and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      held_arrow_q <= 4'b0000;
      held_wasd_q  <= 4'b0000;
      last_q       <= 4'b0000;
      dir_q        <= 4'b0000;
      any_key_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      held_arrow_q <= held_arrow_d;
      held_wasd_q  <= held_wasd_d;
      last_q       <= last_d;
      dir_q        <= dir_s;
      any_key_q    <= |held_all_s;
    end
  end

  assign turn_right    = dir_q[3];
  assign turn_left     = dir_q[2];
  assign move_forward  = dir_q[1];
  assign move_backward = dir_q[0];
  assign any_key       = any_key_q;

endmodule

// File: tb/tb_key_decoder.sv
// Directed self-checking bench for key_decoder (PREFIX_TIMEOUT shortened to 8).
// Observed vector per check: {any_key, turn_right, turn_left, move_forward, move_backward}.

module tb_key_decoder;

  localparam int TMO = 8;

  logic       clock;
  logic       reset;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       turn_right;
  logic       turn_left;
  logic       move_forward;
  logic       move_backward;
  logic       any_key;

  int err_cnt;
  int chk_cnt;

  key_decoder #(.PREFIX_TIMEOUT(TMO)) dut (
    .clock         (clock),
    .reset         (reset),
    .byte_valid    (byte_valid),
    .byte_data     (byte_data),
    .turn_right    (turn_right),
    .turn_left     (turn_left),
    .move_forward  (move_forward),
    .move_backward (move_backward),
    .any_key       (any_key)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [4:0] outs();
    return {any_key, turn_right, turn_left, move_forward, move_backward};
  endfunction

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    chk_cnt = chk_cnt + 1;
    if (got !== exp) begin
      err_cnt = err_cnt + 1;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Present one byte (valid stays high so successive calls are back-to-back)
  task automatic put(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clock);
  endtask

  task automatic stop();
    byte_valid = 1'b0;
    byte_data  = 8'h00;
  endtask

  task automatic gap(input int n);
    byte_valid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  initial begin
    err_cnt    = 0;
    chk_cnt    = 0;
    reset      = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (2) @(negedge clock);
    check("reset_outs", outs(), 5'b00000);
    reset = 1'b0;
    gap(1);

    // Forward make then extended break
    put(8'hE0); put(8'h75); stop();
    check("fwd_make", outs(), 5'b10010);
    put(8'hE0); put(8'hF0); put(8'h75); stop();
    check("fwd_break", outs(), 5'b00000);

    // Most recent wins, then falls back
    put(8'hE0); put(8'h75); stop();
    check("up_make", outs(), 5'b10010);
    put(8'hE0); put(8'h74); stop();
    check("right_over_up", outs(), 5'b11000);
    put(8'hE0); put(8'hF0); put(8'h74); stop();
    check("back_to_up", outs(), 5'b10010);
    put(8'hE0); put(8'hF0); put(8'h75); stop();
    check("up_release", outs(), 5'b00000);

    // Priority fallback: last (right) released, up and down held -> up
    put(8'hE0); put(8'h75); put(8'hE0); put(8'h72); stop();
    check("down_recent", outs(), 5'b10001);
    put(8'hE0); put(8'h74); put(8'hE0); put(8'hF0); put(8'h74); stop();
    check("prio_up_over_down", outs(), 5'b10010);
    put(8'hE0); put(8'hF0); put(8'h75); stop();
    check("prio_down_only", outs(), 5'b10001);
    put(8'hE0); put(8'hF0); put(8'h72); stop();
    check("prio_none", outs(), 5'b00000);

    // Typematic repeats of left
    for (int i = 0; i < 5; i++) begin
      put(8'hE0); put(8'h6B); stop();
      check("typematic_left", outs(), 5'b10100);
      gap(1);
    end
    put(8'hE0); put(8'hF0); put(8'h6B); stop();
    check("typematic_break", outs(), 5'b00000);

    // Releasing keys that are not held
    put(8'hE0); put(8'hF0); put(8'h74); stop();
    check("rel_not_held_idle", outs(), 5'b00000);
    put(8'hE0); put(8'h75); put(8'hE0); put(8'hF0); put(8'h72); stop();
    check("rel_not_held_keep", outs(), 5'b10010);
    // Non-extended break of 75 must not clear the arrow key
    put(8'hF0); put(8'h75); stop();
    check("nonext_break", outs(), 5'b10010);
    put(8'hE0); put(8'hF0); put(8'h75); stop();
    check("clean1", outs(), 5'b00000);
    // Non-extended make of an arrow code is ignored
    put(8'h74); stop();
    check("nonext_make", outs(), 5'b00000);

    // Latency: not visible before the completing edge, visible after
    put(8'hE0);
    byte_valid = 1'b1;
    byte_data  = 8'h74;
    #1;
    check("latency_pre", outs(), 5'b00000);
    @(negedge clock);
    stop();
    check("latency_post", outs(), 5'b11000);
    put(8'hE0); put(8'hF0); put(8'h74); stop();
    check("clean2", outs(), 5'b00000);

    // Spaced bytes inside a prefix
    put(8'hE0); stop(); gap(2); put(8'h74); stop();
    check("spaced_bytes", outs(), 5'b11000);
    put(8'hE0); put(8'hF0); put(8'h74); stop();
    check("clean3", outs(), 5'b00000);

    // Byte arriving on the timeout cycle is still processed
    put(8'hE0); stop(); gap(TMO - 1); put(8'h74); stop();
    check("tmo_edge_byte", outs(), 5'b11000);
    put(8'hE0); put(8'hF0); put(8'h74); stop();
    check("clean4", outs(), 5'b00000);

    // Full timeout: 74 becomes non-extended and is ignored
    put(8'hE0); stop(); gap(TMO); put(8'h74); stop();
    check("tmo_expired", outs(), 5'b00000);

    // Timeout keeps held keys; abandoned E0 F0 does not release
    put(8'hE0); put(8'h75); stop();
    put(8'hE0); put(8'hF0); stop(); gap(TMO);
    check("tmo_held_kept", outs(), 5'b10010);
    put(8'h75); stop();
    check("tmo_no_release", outs(), 5'b10010);

    // Reset between E0 and F0 with a key held
    put(8'hE0); stop();
    reset = 1'b1;
    #1;
    check("async_reset", outs(), 5'b00000);
    @(negedge clock);
    reset = 1'b0;
    put(8'h74); stop();
    check("reset_mid_seq", outs(), 5'b00000);
    check("reset_state_idle", 5'(dut.state_q), 5'b00000);
    put(8'hE0); put(8'h75); stop();
    check("after_reset_fwd", outs(), 5'b10010);
    put(8'hE0); put(8'hF0); put(8'h75); stop();
    check("clean5", outs(), 5'b00000);

`ifdef KEY_WASD_EN
    put(8'h1D); stop();
    check("wasd_w_make", outs(), 5'b10010);
    put(8'hE0); put(8'h75); stop();
    check("wasd_plus_arrow", outs(), 5'b10010);
    put(8'hF0); put(8'h1D); stop();
    check("wasd_w_break", outs(), 5'b10010);
    put(8'hE0); put(8'hF0); put(8'h75); stop();
    check("wasd_all_off", outs(), 5'b00000);
    put(8'h23); stop();
    check("wasd_d_make", outs(), 5'b11000);
    put(8'hF0); put(8'h23); stop();
    check("wasd_d_break", outs(), 5'b00000);
`else
    put(8'h1D); stop();
    check("no_wasd_w", outs(), 5'b00000);
    put(8'h23); stop();
    check("no_wasd_d", outs(), 5'b00000);
`endif

    gap(2);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
